// File: rtl/vadd_float_ctrl_pkg.sv
// vadd_float_ctrl_pkg: register map, status bit positions, FSM states and strobe merge for the vadd_float control slave.
package vadd_float_ctrl_pkg;

  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_GIE       = 6'h04;
  localparam logic [5:0] ADDR_IER       = 6'h08;
  localparam logic [5:0] ADDR_ISR       = 6'h0C;
  localparam logic [5:0] ADDR_XFER_SIZE = 6'h10;
  localparam logic [5:0] ADDR_A_LO      = 6'h18;
  localparam logic [5:0] ADDR_A_HI      = 6'h1C;
  localparam logic [5:0] ADDR_B_LO      = 6'h24;
  localparam logic [5:0] ADDR_B_HI      = 6'h28;
  localparam logic [5:0] ADDR_C_LO      = 6'h30;
  localparam logic [5:0] ADDR_C_HI      = 6'h34;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_IDLE  = 2;
  localparam int CTRL_READY = 3;
  localparam int CTRL_AUTO  = 7;
  localparam int ISR_DONE   = 0;
  localparam int ISR_READY  = 1;

  typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wstate_t;
  typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rstate_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return (data & m) | (old & ~m);
  endfunction

endpackage

// File: rtl/vadd_float_control_s_axi.sv
// vadd_float_control_s_axi: AXI4-Lite register file driving the vadd_float core arguments, start/status and host interrupt.
module vadd_float_control_s_axi
  import vadd_float_ctrl_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            s_axi_control_AWVALID,
  output logic                            s_axi_control_AWREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_AWADDR,
  input  logic                            s_axi_control_WVALID,
  output logic                            s_axi_control_WREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_WSTRB,
  output logic                            s_axi_control_BVALID,
  input  logic                            s_axi_control_BREADY,
  output logic [1:0]                      s_axi_control_BRESP,
  input  logic                            s_axi_control_ARVALID,
  output logic                            s_axi_control_ARREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_ARADDR,
  output logic                            s_axi_control_RVALID,
  input  logic                            s_axi_control_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_RDATA,
  output logic [1:0]                      s_axi_control_RRESP,
  output logic                            interrupt,
  output logic                            ap_start,
  input  logic                            ap_done,
  input  logic                            ap_idle,
  input  logic                            ap_ready,
  output logic [C_XFER_SIZE_WIDTH-1:0]    xfer_size,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   a,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   b,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   c
);

  localparam bit WIDE = C_M_AXI_ADDR_WIDTH > 32;

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;
  logic [3:0] waddr;
  logic [5:0] woff, roff;
  logic aw_hs, w_hs, ar_hs;
  logic wr_ctrl, wr_gie, wr_ier, wr_isr;
  logic [31:0] int_xfer, rdata, rdata_next, ctrl_word;
  logic [63:0] int_a, int_b, int_c;
  logic int_ap_start, int_ap_done, auto_restart, gie, int_interrupt;
  logic [1:0] ier, isr, ev;
  logic unused_addr;

  assign unused_addr = ^{s_axi_control_AWADDR, s_axi_control_ARADDR};
  assign aw_hs = s_axi_control_AWVALID & s_axi_control_AWREADY;
  assign w_hs  = s_axi_control_WVALID & s_axi_control_WREADY;
  assign ar_hs = s_axi_control_ARVALID & s_axi_control_ARREADY;
  assign woff  = {waddr, 2'b00};
  assign roff  = {s_axi_control_ARADDR[5:2], 2'b00};

  assign wr_ctrl = w_hs && woff == ADDR_CTRL && s_axi_control_WSTRB[0];
  assign wr_gie  = w_hs && woff == ADDR_GIE  && s_axi_control_WSTRB[0];
  assign wr_ier  = w_hs && woff == ADDR_IER  && s_axi_control_WSTRB[0];
  assign wr_isr  = w_hs && woff == ADDR_ISR  && s_axi_control_WSTRB[0];

  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) wstate <= WRRESET;
    else wstate <= wnext;

  always_comb
    wnext = wstate == WRRESET ? WRIDLE :
            (wstate == WRIDLE && s_axi_control_AWVALID) ? WRDATA :
            (wstate == WRDATA && s_axi_control_WVALID) ? WRRESP :
            (wstate == WRRESP && s_axi_control_BREADY) ? WRIDLE : wstate;

  always_comb begin
    s_axi_control_AWREADY = wstate == WRIDLE;
    s_axi_control_WREADY  = wstate == WRDATA;
    s_axi_control_BVALID  = wstate == WRRESP;
    s_axi_control_BRESP   = 2'b00;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) rstate <= RDRESET;
    else rstate <= rnext;

  always_comb
    rnext = rstate == RDRESET ? RDIDLE :
            (rstate == RDIDLE && s_axi_control_ARVALID) ? RDDATA :
            (rstate == RDDATA && s_axi_control_RREADY) ? RDIDLE : rstate;

  always_comb begin
    s_axi_control_ARREADY = rstate == RDIDLE;
    s_axi_control_RVALID  = rstate == RDDATA;
    s_axi_control_RRESP   = 2'b00;
    s_axi_control_RDATA   = rdata;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) waddr <= '0;
    else if (aw_hs) waddr <= s_axi_control_AWADDR[5:2];

  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      int_xfer <= '0;
      int_a    <= '0;
      int_b    <= '0;
      int_c    <= '0;
    end else if (w_hs) begin
      if (woff == ADDR_XFER_SIZE) int_xfer <= apply_wstrb(int_xfer, s_axi_control_WDATA, s_axi_control_WSTRB);
      if (woff == ADDR_A_LO) int_a[31:0]  <= apply_wstrb(int_a[31:0],  s_axi_control_WDATA, s_axi_control_WSTRB);
      if (woff == ADDR_A_HI) int_a[63:32] <= apply_wstrb(int_a[63:32], s_axi_control_WDATA, s_axi_control_WSTRB);
      if (woff == ADDR_B_LO) int_b[31:0]  <= apply_wstrb(int_b[31:0],  s_axi_control_WDATA, s_axi_control_WSTRB);
      if (woff == ADDR_B_HI) int_b[63:32] <= apply_wstrb(int_b[63:32], s_axi_control_WDATA, s_axi_control_WSTRB);
      if (woff == ADDR_C_LO) int_c[31:0]  <= apply_wstrb(int_c[31:0],  s_axi_control_WDATA, s_axi_control_WSTRB);
      if (woff == ADDR_C_HI) int_c[63:32] <= apply_wstrb(int_c[63:32], s_axi_control_WDATA, s_axi_control_WSTRB);
    end

  always_comb begin
    ev = '0;
    ev[ISR_DONE]  = ap_done;
    ev[ISR_READY] = ap_ready;
  end

  // Event sets are OR-ed after the toggle so a same-cycle set always wins.
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      int_ap_start  <= 1'b0;
      int_ap_done   <= 1'b0;
      auto_restart  <= 1'b0;
      gie           <= 1'b0;
      ier           <= '0;
      isr           <= '0;
      int_interrupt <= 1'b0;
    end else begin
      int_ap_start  <= (wr_ctrl && s_axi_control_WDATA[CTRL_START]) ? 1'b1 : ap_ready ? auto_restart : int_ap_start;
      int_ap_done   <= ap_done | (int_ap_done & ~(ar_hs && roff == ADDR_CTRL));
      auto_restart  <= wr_ctrl ? s_axi_control_WDATA[CTRL_AUTO] : auto_restart;
      gie           <= wr_gie ? s_axi_control_WDATA[0] : gie;
      ier           <= wr_ier ? s_axi_control_WDATA[1:0] : ier;
      isr           <= (isr ^ (wr_isr ? s_axi_control_WDATA[1:0] : 2'b00)) | (ier & ev);
      int_interrupt <= gie & (|isr);
    end

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_START] = int_ap_start;
    ctrl_word[CTRL_DONE]  = int_ap_done;
    ctrl_word[CTRL_IDLE]  = ap_idle;
    ctrl_word[CTRL_READY] = ap_ready;
    ctrl_word[CTRL_AUTO]  = auto_restart;
  end

  always_comb begin
    rdata_next = '0;
    case (roff)
      ADDR_CTRL:      rdata_next = ctrl_word;
      ADDR_GIE:       rdata_next = {31'd0, gie};
      ADDR_IER:       rdata_next = {30'd0, ier};
      ADDR_ISR:       rdata_next = {30'd0, isr};
      ADDR_XFER_SIZE: rdata_next = int_xfer;
      ADDR_A_LO:      rdata_next = int_a[31:0];
      ADDR_A_HI:      rdata_next = WIDE ? int_a[63:32] : 32'd0;
      ADDR_B_LO:      rdata_next = int_b[31:0];
      ADDR_B_HI:      rdata_next = WIDE ? int_b[63:32] : 32'd0;
      ADDR_C_LO:      rdata_next = int_c[31:0];
      ADDR_C_HI:      rdata_next = WIDE ? int_c[63:32] : 32'd0;
      default:        rdata_next = '0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) rdata <= '0;
    else if (ar_hs) rdata <= rdata_next;

  assign interrupt = int_interrupt;
  assign ap_start  = int_ap_start;
  assign xfer_size = int_xfer[C_XFER_SIZE_WIDTH-1:0];
  assign a         = int_a[C_M_AXI_ADDR_WIDTH-1:0];
  assign b         = int_b[C_M_AXI_ADDR_WIDTH-1:0];
  assign c         = int_c[C_M_AXI_ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_vadd_float_control_s_axi.sv
// tb_vadd_float_control_s_axi: directed self-checking bench for the vadd_float AXI4-Lite control slave.
module tb_vadd_float_control_s_axi;

  logic clk = 1'b0;
  logic rst_n;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [5:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic irq, ap_start, ap_done, ap_idle, ap_ready;
  logic [31:0] xfer_size;
  logic [63:0] a, b, c;
  int checks = 0;
  int errors = 0;
  logic start_at_b;
  logic [31:0] rd_val;

  always #5 clk = ~clk;

  vadd_float_control_s_axi dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready), .s_axi_control_AWADDR(awaddr),
    .s_axi_control_WVALID(wvalid), .s_axi_control_WREADY(wready), .s_axi_control_WDATA(wdata),
    .s_axi_control_WSTRB(wstrb), .s_axi_control_BVALID(bvalid), .s_axi_control_BREADY(bready),
    .s_axi_control_BRESP(bresp), .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready),
    .s_axi_control_ARADDR(araddr), .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready),
    .s_axi_control_RDATA(rdata), .s_axi_control_RRESP(rresp), .interrupt(irq),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .xfer_size(xfer_size), .a(a), .b(b), .c(c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] ad, input logic [31:0] d, input logic [3:0] s);
    awvalid = 1'b1;
    awaddr  = ad;
    for (int i = 0; i < 20 && !awready; i++) step();
    check("aw_ready_wait", awready, 1);
    step();
    awvalid = 1'b0;
    wvalid  = 1'b1;
    wdata   = d;
    wstrb   = s;
    for (int i = 0; i < 20 && !wready; i++) step();
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 20 && !bvalid; i++) step();
    check("b_valid_wait", bvalid, 1);
    start_at_b = ap_start;
    step();
  endtask

  task automatic rd(input logic [5:0] ad, output logic [31:0] d);
    arvalid = 1'b1;
    araddr  = ad;
    for (int i = 0; i < 20 && !arready; i++) step();
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 20 && !rvalid; i++) step();
    check("r_valid_wait", rvalid, 1);
    d = rdata;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    {awvalid, wvalid, arvalid, ap_done, ap_ready} = '0;
    {bready, rready, ap_idle} = 3'b111;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) step();
    check("rst_ready", {awready, arready, wready}, 3'b000);
    check("rst_valid", {bvalid, rvalid, ap_start, irq}, 4'b0000);
    check("rst_a", a, 64'd0);
    rst_n = 1'b1;
    check("wrreset_cycle", {awready, arready}, 2'b00);
    step();
    check("idle_ready", {awready, arready}, 2'b11);
    rd(6'h00, rd_val);
    check("ctrl_after_reset", rd_val, 32'h4);

    wr(6'h10, 32'h0000_0400, 4'b0011);
    check("xfer_size_lo", xfer_size, 32'h400);
    rd(6'h10, rd_val);
    check("xfer_read", rd_val, 32'h400);
    wr(6'h10, 32'hFFFF_FFFF, 4'b1000);
    check("xfer_strb_top", xfer_size, 32'hFF00_0400);

    wr(6'h18, 32'hDEAD_BEEF, 4'hF);
    wr(6'h1C, 32'h0000_0001, 4'hF);
    check("a_value", a, 64'h1_DEAD_BEEF);
    rd(6'h20, rd_val);
    check("unmapped_read", rd_val, 32'h0);
    rd(6'h1C, rd_val);
    check("a_hi_read", rd_val, 32'h1);
    check("b_untouched", b, 64'd0);

    wr(6'h08, 32'h1, 4'h1);
    wr(6'h04, 32'h1, 4'h1);
    check("start_before", ap_start, 1'b0);
    wr(6'h00, 32'h1, 4'h1);
    check("start_after_w", start_at_b, 1'b1);
    ap_ready = 1'b1;
    ap_done  = 1'b1;
    step();
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    check("start_fall", ap_start, 1'b0);
    check("irq_lag1", irq, 1'b0);
    step();
    check("irq_lag2", irq, 1'b1);
    rd(6'h00, rd_val);
    check("ctrl_done_set", rd_val, 32'h6);
    rd(6'h00, rd_val);
    check("ctrl_done_cleared", rd_val, 32'h4);
    rd(6'h0C, rd_val);
    check("isr_masked_ready", rd_val, 32'h1);
    wr(6'h0C, 32'h1, 4'h1);
    check("irq_cleared", irq, 1'b0);
    rd(6'h0C, rd_val);
    check("isr_toggled", rd_val, 32'h0);

    wr(6'h00, 32'h81, 4'h1);
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    check("auto_restart_hold", ap_start, 1'b1);
    rd(6'h00, rd_val);
    check("ctrl_auto_read", rd_val, 32'h85);
    wr(6'h00, 32'h00, 4'h1);
    check("start_w1s_keep", ap_start, 1'b1);
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    check("start_fall_noauto", ap_start, 1'b0);
    wr(6'h00, 32'h1, 4'b0010);
    check("ctrl_strb0_ignored", ap_start, 1'b0);
    check("irq_quiet", irq, 1'b0);

    bready  = 1'b0;
    awvalid = 1'b1;
    awaddr  = 6'h30;
    step();
    awvalid = 1'b0;
    wvalid  = 1'b1;
    wdata   = 32'h1122_3344;
    wstrb   = 4'hF;
    step();
    wvalid  = 1'b0;
    awvalid = 1'b1;
    awaddr  = 6'h34;
    check("c_written", c, 64'h0000_0000_1122_3344);
    for (int i = 0; i < 5; i++) begin
      check("b_stall", {bvalid, awready}, 2'b10);
      step();
    end
    awvalid = 1'b0;
    bready  = 1'b1;
    step();
    check("b_released", {bvalid, awready}, 2'b01);

    rready  = 1'b0;
    arvalid = 1'b1;
    araddr  = 6'h18;
    step();
    araddr  = 6'h10;
    for (int i = 0; i < 5; i++) begin
      check("r_stall", {rvalid, arready}, 2'b10);
      check("r_data_hold", rdata, 32'hDEAD_BEEF);
      step();
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    step();
    check("r_released", {rvalid, arready}, 2'b01);

    awvalid = 1'b1;
    awaddr  = 6'h18;
    step();
    awvalid = 1'b0;
    wvalid  = 1'b1;
    wdata   = 32'h0;
    wstrb   = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    wvalid = 1'b0;
    check("abort_handshakes", {awready, wready, bvalid, arready, rvalid}, 5'b00000);
    check("abort_regs", {a, xfer_size}, 96'd0);
    step();
    rst_n = 1'b1;
    check("abort_wrreset", awready, 1'b0);
    step();
    check("abort_recovered", {awready, arready, bvalid}, 3'b110);
    rd(6'h18, rd_val);
    check("abort_a_lo", rd_val, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vadd_float_control_s_axi.md
# vadd_float_control_s_axi

AXI4-Lite slave register file for the vadd_float kernel. It sits directly upstream of the vadd_float kernel core and drives the core's ap_start, xfer_size, a, b and c inputs. It consumes the core's ap_done, ap_idle and ap_ready, and raises a host interrupt. Host software writes the arguments, sets ap_start, then polls or waits for the interrupt.

## Interface
- C_S_AXI_ADDR_WIDTH, 6: control address width; register map occupies 0x00–0x37.
- C_S_AXI_DATA_WIDTH, 32: control data width; fixed, other values unsupported.
- C_M_AXI_ADDR_WIDTH, 64: width of the a/b/c pointer outputs.
- C_XFER_SIZE_WIDTH, 32: width of the xfer_size output.

Ports:
- ap_clk  in  1  kernel clock; the only clock.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- s_axi_control_AWVALID/AWREADY  in/out  1  write-address handshake.
- s_axi_control_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address.
- s_axi_control_WVALID/WREADY  in/out  1  write-data handshake.
- s_axi_control_WDATA  in  32  write data.
- s_axi_control_WSTRB  in  4  byte enables.
- s_axi_control_BVALID/BREADY  out/in  1  write response handshake.
- s_axi_control_BRESP  out  2  always 2'b00.
- s_axi_control_ARVALID/ARREADY  in/out  1  read-address handshake.
- s_axi_control_ARADDR  in  C_S_AXI_ADDR_WIDTH  read byte address.
- s_axi_control_RVALID/RREADY  out/in  1  read-data handshake.
- s_axi_control_RDATA  out  32  read data.
- s_axi_control_RRESP  out  2  always 2'b00.
- interrupt  out  1  level interrupt to host.
- ap_start  out  1  start request to core.
- ap_done, ap_idle, ap_ready  in  1  core status; done and ready are one-cycle pulses.
- xfer_size  out  C_XFER_SIZE_WIDTH  element count.
- a, b, c  out  C_M_AXI_ADDR_WIDTH  operand and result base addresses.

## Operation

Register map (low 6 address bits decoded, bits [1:0] ignored):
- 0x00 CTRL:
  - bit0 ap_start: R/W1S.
  - bit1 ap_done: clear-on-read.
  - bit2 ap_idle: live input.
  - bit3 ap_ready: live input.
  - bit7 auto_restart: R/W.
- 0x04 GIE: bit0 global interrupt enable.
- 0x08 IER: bit0 done enable, bit1 ready enable.
- 0x0C ISR: bit0 done, bit1 ready; each bit toggles on a write of 1.
- 0x10 xfer_size.
- 0x18/0x1C: a[31:0] / a[63:32].
- 0x24/0x28: b low / b high.
- 0x30/0x34: c low / c high.

Write behaviour:
- Argument registers honour WSTRB per byte.
- CTRL, GIE, IER and ISR act only when WSTRB[0]=1.
- Writes to unmapped offsets are ignored; the response is still OKAY.

Reads:
- Unmapped offsets return 0.
- The high words of a/b/c return 0 when C_M_AXI_ADDR_WIDTH ≤ 32.

Write FSM: WRRESET → WRIDLE → WRDATA → WRRESP → WRIDLE.
- WRRESET lasts one cycle after reset release.
- WRIDLE: AWREADY=1; AW handshake latches AWADDR and moves to WRDATA.
- WRDATA: WREADY=1; W handshake performs the write and moves to WRRESP.
- WRRESP: BVALID=1 until BREADY, then WRIDLE.

Read FSM: RDRESET → RDIDLE → RDDATA → RDIDLE.
- RDIDLE: ARREADY=1; AR handshake moves to RDDATA and registers RDATA.
- RDDATA: RVALID=1; RDATA is held stable until RREADY.

Control behaviour:
- ap_start is set by writing 1 to CTRL bit0.
- On an ap_ready pulse, ap_start copies auto_restart.
- ap_done status bit is set by an ap_done pulse and cleared by an AR handshake to 0x00.
- If set and clear occur in the same cycle, the bit stays set.
- ISR bit n is set by its event when IER bit n=1. If a toggle-write and a set occur in the same cycle, set wins.
- interrupt = GIE & (ISR[0] | ISR[1]), registered.

## Timing
- Reset:
  - All outputs 0 while ap_rst_n=0 and for the WRRESET/RDRESET cycle, including the AWREADY and ARREADY ready signals.
  - All registers clear to 0.
- Minimum write: AW accepted cycle N, W accepted N+1, register updated and BVALID high from N+2.
- AW and W are not accepted in the same cycle; a WVALID presented early waits.
- Minimum read: AR accepted cycle N, RVALID from N+1.
- Read and write channels are independent. Same-cycle register write and read of the same address returns the old value.
- ap_start rises the cycle after the W handshake.
- ap_start falls the cycle after an ap_ready pulse (when auto_restart=0).
- interrupt asserts 2 cycles after the ap_done pulse: ISR set, then registered output.
- Asynchronous reset mid-transaction aborts it. No BVALID/RVALID is produced for aborted transfers.

## Structure
- Package vadd_float_ctrl_pkg holds:
  - the register offset localparams (ADDR_CTRL … ADDR_C_HI);
  - the CTRL/ISR bit indices;
  - the write and read FSM state enums.
- Single module; no sub-module is warranted.
- Byte-strobe merge is a package function, apply_wstrb(old, data, strb).

## Test plan
- Reset release → AWREADY/ARREADY 0 for one cycle, then 1; read of 0x00 returns 0x00000004 with ap_idle=1.
- Write 0x10=0x00000400 with WSTRB=4'b0011 → xfer_size=0x00000000_0400 (upper bytes unchanged); read 0x10 returns 0x00000400.
- Write 0x18=0xDEADBEEF and 0x1C=0x00000001 → a=64'h1_DEADBEEF; a read of 0x20 (unmapped) returns 0.
- Write IER=1, GIE=1, CTRL=1 → ap_start=1. Pulse ap_ready plus ap_done → ap_start=0 and interrupt=1 two cycles later. Read CTRL returns bit1=1, next read bit1=0. Write ISR=1 → interrupt=0.
- Write CTRL=0x81 (auto_restart) and pulse ap_ready → ap_start stays 1.
- Hold BREADY=0 for 5 cycles and RREADY=0 for 5 cycles → BVALID/RVALID and RDATA stay stable, and no new AW/AR is accepted.
